panel_scroll_ctrl: RTL and testbench
====================================

PANEL_SCROLL_CTRL -- requirements
Module: panel_scroll_ctrl

Interface
REQ-001 Parameter: TICK_DIV, 50000, clk cycles per base tick (>=2).
REQ-002 Parameter: DIGIT_W, 7, bits per display digit (segments).
REQ-003 Parameter: N_DIGITS, 4, digits in the display word; word width W = DIGIT_W*N_DIGITS = 28.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 clr  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  begin a display run (level, sampled in IDLE).
REQ-007 stop  in  1  end the current run.
REQ-008 mode  in  2  00 static, 01 scroll left, 10 scroll right, 11 blink.
REQ-009 speed  in  4  step period = (speed+1) base ticks.
REQ-010 msg  in  28  message word, 4 digits x 7 segments.
REQ-011 reg_q  in  28  current content of the display shift register.
REQ-012 reg_load  out  1  parallel-load strobe to the shift register.
REQ-013 reg_s  out  2  register op: 00 hold, 01 shift right (insert at bit 27), 10 shift left (insert at bit 0), 11 load.
REQ-014 reg_d  out  28  parallel data to the shift register.
REQ-015 reg_m_sig  out  1  serial bit inserted on a shift.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at end of each full revolution / blink pair.

Function
REQ-018 States: IDLE, LOAD, WAIT, SHIFT, BLINK, HOLD; outputs Moore-decoded from state, except reg_m_sig (combinational from reg_q).
REQ-019 IDLE: start=1 and stop=0 -> LOAD next cycle; msg, mode, speed latched on that edge; later input changes ignored until next IDLE.
REQ-020 LOAD (1 cycle): reg_load=1, reg_s=11, reg_d=latched msg; next WAIT (modes 01/10/11) or HOLD (mode 00).
REQ-021 Base tick: prescaler counts 0..TICK_DIV-1 while busy, held at 0 in IDLE; one-cycle tick at TICK_DIV-1.
REQ-022 WAIT: counts ticks; on the (speed+1)th tick -> SHIFT (modes 01/10) or BLINK (mode 11); tick counter cleared on exit.
REQ-023 SHIFT: exactly DIGIT_W consecutive cycles with reg_s=10 and reg_m_sig=reg_q[27] (left) or reg_s=01 and reg_m_sig=reg_q[0] (right); net effect rotate by one digit; then WAIT.
REQ-024 Digit counter 0..N_DIGITS-1 increments after each SHIFT burst; on wrap N_DIGITS-1 -> 0, done=1 for the cycle following the last shift (register equals msg again).
REQ-025 BLINK (1 cycle): reg_load=1, reg_s=11, reg_d=0 in blank phase, latched msg in show phase; phase toggles each entry, first entry blank; done=1 after each show load; then WAIT.
REQ-026 HOLD: reg_s=00, reg_load=0; stays until stop.
REQ-027 stop=1 in LOAD, WAIT, BLINK or HOLD -> IDLE next cycle; in SHIFT, stop honoured only after the burst completes (digit-aligned display), then IDLE, not WAIT.
REQ-028 start while busy ignored; start and stop together in IDLE -> remain IDLE.
REQ-029 Outside LOAD/BLINK/SHIFT: reg_load=0, reg_s=00, reg_d=0, reg_m_sig=0.

Reset
REQ-030 clr=1 forces IDLE, prescaler, tick counter, digit counter, blink phase and latched registers to 0 immediately, including mid-burst.
REQ-031 During and after reset until start: reg_load=0, reg_s=00, reg_d=0, reg_m_sig=0, busy=0, done=0.

Structure
REQ-032 Shared package panel_pkg holds state encoding, mode codes, reg_s op codes (HOLD/RIGHT/LEFT/LOAD) and DIGIT_W/N_DIGITS defaults.
REQ-033 Prescaler is a separate sub-module panel_tick_gen (enable, tick output); FSM, counters, and latches stay in panel_scroll_ctrl.

Verification (TICK_DIV=2, speed=0, bench includes the shift register model)
REQ-034 msg=28'h1234567, mode=01, start -> after first SHIFT burst reg_q == {msg[20:0],msg[27:21]}; exactly 7 cycles with reg_s=10.
REQ-035 Same msg, mode=10 -> after first burst reg_q == {msg[6:0],msg[27:7]}; after 4 bursts reg_q == msg and done pulses once.
REQ-036 mode=11 -> reg_q sequence msg, 0, msg, 0...; done after each return to msg; period 2 ticks per phase.
REQ-037 mode=01, stop asserted on 3rd cycle of a burst -> 7 shifts still complete, then IDLE, busy=0, reg_q digit-aligned.
REQ-038 clr pulse mid-burst -> all outputs 0 same cycle, IDLE; start after release reloads msg.
REQ-039 mode=00 -> one load, reg_s=00 thereafter, no done; start while busy ignored; stop -> IDLE.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared encodings for the panel scroll controller.
package panel_pkg;
  localparam int DIGIT_W_DEF  = 7;
  localparam int N_DIGITS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_BLINK = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_RIGHT = 2'b01,
    OP_LEFT  = 2'b10,
    OP_LOAD  = 2'b11
  } reg_op_e;
endpackage

// File: rtl/panel_tick_gen.sv
// Base-tick prescaler: free-runs while enabled, parked at zero otherwise.
module panel_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: wrap at LAST, restart from zero whenever disabled
  always_comb begin
    cnt_d = '0;
    if (en && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);
endmodule

// File: rtl/panel_scroll_ctrl.sv
// Display scroll/blink sequencer driving an external shift register.
module panel_scroll_ctrl
  import panel_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DIGIT_W  = DIGIT_W_DEF,
  parameter int N_DIGITS = N_DIGITS_DEF,
  localparam int W       = DIGIT_W * N_DIGITS
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
  input  logic [3:0]   speed,
  input  logic [W-1:0] msg,
  input  logic [W-1:0] reg_q,
  output logic         reg_load,
  output logic [1:0]   reg_s,
  output logic [W-1:0] reg_d,
  output logic         reg_m_sig,
  output logic         busy,
  output logic         done
);
  localparam int BW  = (DIGIT_W  > 1) ? $clog2(DIGIT_W)  : 1;
  localparam int DGW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_e         state_q, state_d;
  mode_e          mode_q;
  logic [W-1:0]   msg_q;
  logic [3:0]     speed_q, tick_cnt_q;
  logic [BW-1:0]  bit_q;
  logic [DGW-1:0] dig_q;
  logic           show_q, stop_pend_q, done_q;
  logic           tick, bit_last, dig_last;
  reg_op_e        op;
  logic           unused_reg_bits;

  // only the two end bits of the register feed the serial input
  assign unused_reg_bits = ^reg_q[W-2:1];

  assign bit_last = (bit_q == BW'(DIGIT_W - 1));
  assign dig_last = (dig_q == DGW'(N_DIGITS - 1));
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  panel_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .en   (busy),
    .tick (tick)
  );

  // state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next-state; a stop during a shift burst waits for digit alignment
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_LOAD;
      ST_LOAD:  state_d = stop ? ST_IDLE : (mode_q == MODE_STATIC) ? ST_HOLD : ST_WAIT;
      ST_WAIT:  if (stop) state_d = ST_IDLE;
                else if (tick && tick_cnt_q == speed_q)
                  state_d = (mode_q == MODE_BLINK) ? ST_BLINK : ST_SHIFT;
      ST_SHIFT: if (bit_last) state_d = (stop || stop_pend_q) ? ST_IDLE : ST_WAIT;
      ST_BLINK: state_d = stop ? ST_IDLE : ST_WAIT;
      ST_HOLD:  if (stop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // run latches, step/bit/digit counters, blink phase and done pulse
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      msg_q       <= '0;
      mode_q      <= MODE_STATIC;
      speed_q     <= '0;
      tick_cnt_q  <= '0;
      bit_q       <= '0;
      dig_q       <= '0;
      show_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start && !stop) begin
          msg_q   <= msg;
          mode_q  <= mode_e'(mode);
          speed_q <= speed;
          show_q  <= 1'b0;
          dig_q   <= '0;
        end
        ST_WAIT: begin
          if (state_d != ST_WAIT) tick_cnt_q <= '0;
          else if (tick)          tick_cnt_q <= tick_cnt_q + 4'd1;
        end
        ST_SHIFT: begin
          if (stop) stop_pend_q <= 1'b1;
          if (bit_last) begin
            bit_q       <= '0;
            stop_pend_q <= 1'b0;
            dig_q       <= dig_last ? '0 : dig_q + 1'b1;
            done_q      <= dig_last;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        ST_BLINK: begin
          show_q <= !show_q;
          done_q <= show_q;
        end
        default: ;
      endcase
    end
  end

  // register-port decode from state; serial bit follows the rotate direction
  always_comb begin
    op        = OP_HOLD;
    reg_d     = '0;
    reg_m_sig = 1'b0;
    case (state_q)
      ST_LOAD: begin
        op    = OP_LOAD;
        reg_d = msg_q;
      end
      ST_BLINK: begin
        op    = OP_LOAD;
        reg_d = show_q ? msg_q : '0;
      end
      ST_SHIFT: begin
        if (mode_q == MODE_LEFT) begin
          op        = OP_LEFT;
          reg_m_sig = reg_q[W-1];
        end else begin
          op        = OP_RIGHT;
          reg_m_sig = reg_q[0];
        end
      end
      default: ;
    endcase
  end

  assign reg_s    = op;
  assign reg_load = (op == OP_LOAD);
endmodule

// File: tb/tb_panel_scroll_ctrl.sv
// Bench: external shift register, behavioural model, per-cycle compare, directed + random runs.
module tb_panel_scroll_ctrl;
  localparam int TD = 2, DW = 7, ND = 4, W = DW * ND;
  localparam logic [W-1:0] MSG = 28'h1234567;
  localparam int S_IDLE = 0, S_LOAD = 1, S_WAIT = 2, S_SHIFT = 3, S_BLINK = 4, S_HOLD = 5;

  logic clk = 1'b0, clr = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] speed = 4'd0;
  logic [W-1:0] msg = '0;
  logic [W-1:0] reg_q;
  logic reg_load, reg_m_sig, busy, done;
  logic [1:0] reg_s;
  logic [W-1:0] reg_d;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  panel_scroll_ctrl #(.TICK_DIV(TD), .DIGIT_W(DW), .N_DIGITS(ND)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .mode(mode), .speed(speed),
    .msg(msg), .reg_q(reg_q), .reg_load(reg_load), .reg_s(reg_s), .reg_d(reg_d),
    .reg_m_sig(reg_m_sig), .busy(busy), .done(done)
  );

  // external display shift register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) reg_q <= '0;
    else case (reg_s)
      2'b11:   reg_q <= reg_d;
      2'b10:   reg_q <= {reg_q[W-2:0], reg_m_sig};
      2'b01:   reg_q <= {reg_m_sig, reg_q[W-1:1]};
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st = S_IDLE, m_pre = 0, m_waited = 0, m_sh = 0, m_bursts = 0;
  int m_mode = 0, m_spd = 0;
  bit m_show = 0, m_spend = 0, m_done = 0;
  logic [W-1:0] m_msg = '0, m_cur = '0;

  task automatic m_reset();
    m_st = S_IDLE; m_pre = 0; m_waited = 0; m_sh = 0; m_bursts = 0;
    m_mode = 0; m_spd = 0; m_show = 0; m_spend = 0; m_done = 0;
    m_msg = '0; m_cur = '0;
  endtask

  task automatic m_step();
    bit tk, nd;
    int nst;
    tk  = (m_st != S_IDLE) && (m_pre == TD - 1);
    m_pre = (m_st != S_IDLE) ? (m_pre + 1) % TD : 0;
    nst = m_st;
    nd  = 0;
    case (m_st)
      S_IDLE: if (start && !stop) begin
        m_msg = msg; m_mode = int'(mode); m_spd = int'(speed);
        m_show = 0; m_bursts = 0; nst = S_LOAD;
      end
      S_LOAD: begin
        m_cur = m_msg;
        nst = stop ? S_IDLE : (m_mode == 0 ? S_HOLD : S_WAIT);
      end
      S_WAIT: begin
        if (stop) begin m_waited = 0; nst = S_IDLE; end
        else if (tk) begin
          if (m_waited == m_spd) begin m_waited = 0; nst = (m_mode == 3) ? S_BLINK : S_SHIFT; end
          else m_waited++;
        end
      end
      S_SHIFT: begin
        m_cur = (m_mode == 1) ? {m_cur[W-2:0], m_cur[W-1]} : {m_cur[0], m_cur[W-1:1]};
        if (stop) m_spend = 1;
        m_sh++;
        if (m_sh == DW) begin
          m_sh = 0;
          m_bursts = (m_bursts + 1) % ND;
          nd = (m_bursts == 0);
          nst = m_spend ? S_IDLE : S_WAIT;
          m_spend = 0;
        end
      end
      S_BLINK: begin
        m_cur = m_show ? m_msg : '0;
        nd = m_show;
        m_show = !m_show;
        nst = stop ? S_IDLE : S_WAIT;
      end
      S_HOLD: if (stop) nst = S_IDLE;
      default: nst = S_IDLE;
    endcase
    m_st = nst;
    m_done = nd;
  endtask

  initial forever begin
    @(posedge clk or posedge clr);
    if (clr) m_reset();
    else     m_step();
  end

  // per-cycle compare against the model
  initial forever begin
    logic [31:0] e_s, e_d, e_m;
    bit e_load;
    @(negedge clk);
    if (chk_en) begin
      e_load = (m_st == S_LOAD) || (m_st == S_BLINK);
      e_s = e_load ? 32'd3 : (m_st == S_SHIFT) ? ((m_mode == 1) ? 32'd2 : 32'd1) : 32'd0;
      e_d = (m_st == S_LOAD || (m_st == S_BLINK && m_show)) ? 32'(m_msg) : 32'd0;
      e_m = (m_st == S_SHIFT) ? ((m_mode == 1) ? 32'(reg_q[W-1]) : 32'(reg_q[0])) : 32'd0;
      chk("busy", 32'(busy), 32'(m_st != S_IDLE));
      chk("done", 32'(done), 32'(m_done));
      chk("reg_load", 32'(reg_load), 32'(e_load));
      chk("reg_s", 32'(reg_s), e_s);
      chk("reg_d", 32'(reg_d), e_d);
      chk("reg_m_sig", 32'(reg_m_sig), e_m);
      chk("reg_q", 32'(reg_q), 32'(m_cur));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_start(input logic [W-1:0] m, input logic [1:0] md, input logic [3:0] sp);
    cyc(); msg = m; mode = md; speed = sp; start = 1'b1;
    cyc(); start = 1'b0;
  endtask

  task automatic do_stop();
    bit idle;
    idle = 0;
    cyc(); stop = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin idle = 1; break; end
    end
    chk("stop_to_idle", 32'(idle), 32'd1);
    cyc(); stop = 1'b0;
  endtask

  task automatic wait_op(input logic [1:0] op, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (reg_s == op) begin ok = 1; break; end
    end
    chk("wait_op_timeout", 32'(ok), 32'd1);
  endtask

  task automatic count_burst(inout int n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (reg_s == 2'b10 || reg_s == 2'b01) n++;
      else break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok, saw_zero;
    int n, dn, bursts;
    logic [1:0] prev_s;
    logic [W-1:0] q_at_done;

    // reset
    cyc(); chk_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_s", 32'(reg_s), 32'd0);
    chk("rst_reg_d", 32'(reg_d), 32'd0);
    cyc(); clr = 1'b0;
    repeat (3) cyc();

    // scroll left: first burst
    do_start(MSG, 2'b01, 4'd0);
    wait_op(2'b10, ok);
    n = ok ? 1 : 0;
    count_burst(n);
    chk("left_shift_cycles", 32'(n), 32'd7);
    chk("left_first_burst", 32'(reg_q), 32'h1A2B389);
    do_stop();

    // scroll right: first burst, then full revolution with one done
    do_start(MSG, 2'b10, 4'd0);
    wait_op(2'b01, ok);
    n = ok ? 1 : 0;
    count_burst(n);
    chk("right_shift_cycles", 32'(n), 32'd7);
    chk("right_first_burst", 32'(reg_q), 32'hCE2468A);
    bursts = 1; dn = 0; prev_s = 2'b00; q_at_done = '0;
    for (int i = 0; i < 300 && dn == 0; i++) begin
      @(negedge clk);
      if (reg_s == 2'b01 && prev_s != 2'b01) bursts++;
      if (done) begin dn++; q_at_done = reg_q; end
      prev_s = reg_s;
    end
    chk("right_rev_done", 32'(dn), 32'd1);
    chk("right_rev_bursts", 32'(bursts), 32'd4);
    chk("right_rev_reg", 32'(q_at_done), 32'(MSG));
    do_stop();

    // blink: blank phase first, done on return to msg
    do_start(MSG, 2'b11, 4'd0);
    saw_zero = 0; dn = 0; q_at_done = '0;
    for (int i = 0; i < 100 && dn == 0; i++) begin
      @(negedge clk);
      if (busy && reg_q == '0) saw_zero = 1;
      if (done) begin dn = 1; q_at_done = reg_q; end
    end
    chk("blink_saw_blank", 32'(saw_zero), 32'd1);
    chk("blink_done", 32'(dn), 32'd1);
    chk("blink_show_reg", 32'(q_at_done), 32'(MSG));
    do_stop();

    // stop on 3rd cycle of a burst: burst completes, then idle
    do_start(MSG, 2'b01, 4'd0);
    wait_op(2'b10, ok);
    n = ok ? 1 : 0;
    @(negedge clk); if (reg_s == 2'b10) n++;
    @(negedge clk); if (reg_s == 2'b10) n++;
    stop = 1'b1;
    @(posedge clk); #2 stop = 1'b0;
    count_burst(n);
    chk("stop_mid_cycles", 32'(n), 32'd7);
    chk("stop_mid_busy", 32'(busy), 32'd0);
    chk("stop_mid_reg", 32'(reg_q), 32'h1A2B389);
    repeat (3) cyc();

    // clr mid-burst
    do_start(MSG, 2'b01, 4'd0);
    wait_op(2'b10, ok);
    @(negedge clk);
    #1 clr = 1'b1;
    #1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_outs", {reg_load, reg_m_sig, done, reg_s}, 32'd0);
    chk("clr_reg_d", 32'(reg_d), 32'd0);
    @(posedge clk); #2 clr = 1'b0;
    do_start(28'h0ABCDEF, 2'b00, 4'd0);
    wait_op(2'b11, ok);
    @(negedge clk);
    chk("clr_reload", 32'(reg_q), 32'h0ABCDEF);

    // static: one load, start while busy ignored, no done
    do_stop();
    do_start(MSG, 2'b00, 4'd0);
    do_start(28'h7777777, 2'b01, 4'd0);
    dn = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (reg_s != 2'b00) n++;
    end
    chk("static_no_done", 32'(dn), 32'd0);
    chk("static_hold_ops", 32'(n), 32'd0);
    chk("static_reg", 32'(reg_q), 32'(MSG));
    do_stop();

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      do_start(W'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 2)));
      n = $urandom_range(30, 250);
      for (int c = 0; c < n; c++) begin
        cyc();
        msg   = W'($urandom);
        mode  = 2'($urandom_range(0, 3));
        speed = 4'($urandom_range(0, 2));
        start = ($urandom_range(0, 9) == 0);
        stop  = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 499) == 0) begin
          clr = 1'b1; cyc(); clr = 1'b0;
        end
      end
      start = 1'b0; stop = 1'b0;
      do_stop();
    end

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
